// File: rtl/id_ex_pipeline_register_if.sv
// Decode-to-execute bus: ID-side control word and operands, flush/freeze controls,
// registered EX-side copies and the load-use stall back to the front end.
interface id_ex_pipeline_register_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  id_valid;
  logic                  id_write;
  logic                  id_store;
  logic                  id_load;
  logic                  id_branch;
  logic [1:0]            id_alu_operand_a_selector;
  logic                  id_alu_operand_b_selector;
  logic [1:0]            id_immediate_selector;
  logic [1:0]            id_next_pc_selector;
  logic [2:0]            id_alu_operations_selector;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic [XLEN-1:0]       id_pc;
  logic [XLEN-1:0]       id_immediate;
  logic                  flush;
  logic                  freeze;

  logic                  stall;
  logic                  ex_valid;
  logic                  ex_write;
  logic                  ex_store;
  logic                  ex_load;
  logic                  ex_branch;
  logic [1:0]            ex_alu_operand_a_selector;
  logic                  ex_alu_operand_b_selector;
  logic [1:0]            ex_immediate_selector;
  logic [1:0]            ex_next_pc_selector;
  logic [2:0]            ex_alu_operations_selector;
  logic [REG_ADDR_W-1:0] ex_rs1;
  logic [REG_ADDR_W-1:0] ex_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic [XLEN-1:0]       ex_pc;
  logic [XLEN-1:0]       ex_immediate;

  modport master (
    output id_valid, id_write, id_store, id_load, id_branch, id_alu_operand_a_selector,
           id_alu_operand_b_selector, id_immediate_selector, id_next_pc_selector,
           id_alu_operations_selector, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
           id_pc, id_immediate, flush, freeze,
    input  stall, ex_valid, ex_write, ex_store, ex_load, ex_branch, ex_alu_operand_a_selector,
           ex_alu_operand_b_selector, ex_immediate_selector, ex_next_pc_selector,
           ex_alu_operations_selector, ex_rs1, ex_rs2, ex_rd, ex_pc, ex_immediate
  );

  modport slave (
    input  id_valid, id_write, id_store, id_load, id_branch, id_alu_operand_a_selector,
           id_alu_operand_b_selector, id_immediate_selector, id_next_pc_selector,
           id_alu_operations_selector, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
           id_pc, id_immediate, flush, freeze,
    output stall, ex_valid, ex_write, ex_store, ex_load, ex_branch, ex_alu_operand_a_selector,
           ex_alu_operand_b_selector, ex_immediate_selector, ex_next_pc_selector,
           ex_alu_operations_selector, ex_rs1, ex_rs2, ex_rd, ex_pc, ex_immediate
  );
endinterface

// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register with load-use bubble insertion, flush and freeze.
// Optional HAZARD_STATS_EN adds saturating stall_count / flush_count outputs.
module id_ex_pipeline_register #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  id_ex_pipeline_register_if.slave bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
`endif
);

  typedef struct packed {
    logic                  valid;
    logic                  write;
    logic                  store;
    logic                  load;
    logic                  branch;
    logic [1:0]            a_sel;
    logic                  b_sel;
    logic [1:0]            imm_sel;
    logic [1:0]            npc_sel;
    logic [2:0]            alu_op;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       imm;
  } ex_t;

  ex_t  ex_d, ex_q, id_cap;
  logic hazard;
  logic stall;

  // Bubble kills control and selectors but keeps data fields.
  function automatic ex_t make_bubble(ex_t x);
    ex_t b;
    b         = x;
    b.valid   = 1'b0;
    b.write   = 1'b0;
    b.store   = 1'b0;
    b.load    = 1'b0;
    b.branch  = 1'b0;
    b.a_sel   = '0;
    b.b_sel   = 1'b0;
    b.imm_sel = '0;
    b.npc_sel = '0;
    b.alu_op  = '0;
    return b;
  endfunction

  always_comb begin
    id_cap.valid   = bus.id_valid;
    id_cap.write   = bus.id_write & bus.id_valid;
    id_cap.store   = bus.id_store & bus.id_valid;
    id_cap.load    = bus.id_load & bus.id_valid;
    id_cap.branch  = bus.id_branch & bus.id_valid;
    id_cap.a_sel   = bus.id_alu_operand_a_selector;
    id_cap.b_sel   = bus.id_alu_operand_b_selector;
    id_cap.imm_sel = bus.id_immediate_selector;
    id_cap.npc_sel = bus.id_valid ? bus.id_next_pc_selector : 2'b00;
    id_cap.alu_op  = bus.id_alu_operations_selector;
    id_cap.rs1     = bus.id_rs1;
    id_cap.rs2     = bus.id_rs2;
    id_cap.rd      = bus.id_rd;
    id_cap.pc      = bus.id_pc;
    id_cap.imm     = bus.id_immediate;
  end

  assign hazard = ex_q.valid & ex_q.load & (ex_q.rd != '0) & bus.id_valid &
                  ((bus.id_uses_rs1 & (bus.id_rs1 == ex_q.rd)) |
                   (bus.id_uses_rs2 & (bus.id_rs2 == ex_q.rd)));
  assign stall  = hazard & ~bus.flush;

  always_comb begin
    ex_d = ex_q;
    if (rst) begin
      ex_d = '0;
    end else if (bus.flush) begin
      ex_d = make_bubble(ex_q);
    end else if (bus.freeze) begin
      ex_d = ex_q;
    end else if (hazard) begin
      ex_d = make_bubble(ex_q);
    end else begin
      ex_d = id_cap;
    end
  end

  always_ff @(posedge clk) begin
    ex_q <= ex_d;
  end

  assign bus.stall                      = stall;
  assign bus.ex_valid                   = ex_q.valid;
  assign bus.ex_write                   = ex_q.write;
  assign bus.ex_store                   = ex_q.store;
  assign bus.ex_load                    = ex_q.load;
  assign bus.ex_branch                  = ex_q.branch;
  assign bus.ex_alu_operand_a_selector  = ex_q.a_sel;
  assign bus.ex_alu_operand_b_selector  = ex_q.b_sel;
  assign bus.ex_immediate_selector      = ex_q.imm_sel;
  assign bus.ex_next_pc_selector        = ex_q.npc_sel;
  assign bus.ex_alu_operations_selector = ex_q.alu_op;
  assign bus.ex_rs1                     = ex_q.rs1;
  assign bus.ex_rs2                     = ex_q.rs2;
  assign bus.ex_rd                      = ex_q.rd;
  assign bus.ex_pc                      = ex_q.pc;
  assign bus.ex_immediate               = ex_q.imm;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count_d, stall_count_q;
  logic [31:0] flush_count_d, flush_count_q;

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (rst) begin
      stall_count_d = '0;
      flush_count_d = '0;
    end else begin
      if (stall && !bus.freeze && (stall_count_q != 32'hFFFF_FFFF)) begin
        stall_count_d = stall_count_q + 32'd1;
      end
      if (bus.flush && !bus.freeze && (flush_count_q != 32'hFFFF_FFFF)) begin
        flush_count_d = flush_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    stall_count_q <= stall_count_d;
    flush_count_q <= flush_count_d;
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Self-checking bench for id_ex_pipeline_register against a behavioural EX-slot model.
// Define HAZARD_STATS_EN to also exercise the stall/flush counters.
module tb_id_ex_pipeline_register;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_pipeline_register_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count, flush_count;
  int unsigned m_stalls, m_flushes;
`endif

  id_ex_pipeline_register #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
`ifdef HAZARD_STATS_EN
    .stall_count (stall_count),
    .flush_count (flush_count),
`endif
    .bus (bus)
  );

  typedef struct packed {
    logic        valid, write, store, load, branch;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic [1:0]  imm_sel, npc_sel;
    logic [2:0]  alu_op;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc, imm;
  } ex_s;

  ex_s m;
  int  checks = 0;
  int  errors = 0;

  function automatic ex_s dut_ex();
    ex_s d;
    d = '{bus.ex_valid, bus.ex_write, bus.ex_store, bus.ex_load, bus.ex_branch,
          bus.ex_alu_operand_a_selector, bus.ex_alu_operand_b_selector,
          bus.ex_immediate_selector, bus.ex_next_pc_selector, bus.ex_alu_operations_selector,
          bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_pc, bus.ex_immediate};
    return d;
  endfunction

  // Load in EX whose nonzero destination is read by a real ID instruction.
  function automatic logic exp_hazard();
    logic reads;
    reads = (bus.id_uses_rs1 && bus.id_rs1 == m.rd) || (bus.id_uses_rs2 && bus.id_rs2 == m.rd);
    return m.valid && m.load && (m.rd != 0) && bus.id_valid && reads;
  endfunction

  function automatic ex_s killed(ex_s x);
    ex_s k;
    k = x;
    {k.valid, k.write, k.store, k.load, k.branch} = 5'b0;
    {k.a_sel, k.b_sel, k.imm_sel, k.npc_sel, k.alu_op} = 10'b0;
    return k;
  endfunction

  function automatic ex_s model_next();
    ex_s n;
    if (rst) n = '0;
    else if (bus.flush) n = killed(m);
    else if (bus.freeze) n = m;
    else if (exp_hazard()) n = killed(m);
    else begin
      n = '{bus.id_valid, bus.id_write, bus.id_store, bus.id_load, bus.id_branch,
            bus.id_alu_operand_a_selector, bus.id_alu_operand_b_selector,
            bus.id_immediate_selector, bus.id_next_pc_selector, bus.id_alu_operations_selector,
            bus.id_rs1, bus.id_rs2, bus.id_rd, bus.id_pc, bus.id_immediate};
      if (!bus.id_valid) {n.write, n.store, n.load, n.branch, n.npc_sel} = 6'b0;
    end
    return n;
  endfunction

  task automatic tick();
    ex_s n;
    n = model_next();
`ifdef HAZARD_STATS_EN
    if (rst) begin
      m_stalls  = 0;
      m_flushes = 0;
    end else if (!bus.freeze) begin
      if (exp_hazard() && !bus.flush) m_stalls++;
      if (bus.flush) m_flushes++;
    end
`endif
    @(posedge clk);
    #1;
    m = n;
  endtask

  task automatic idle();
    bus.id_valid = 0; bus.id_write = 0; bus.id_store = 0; bus.id_load = 0; bus.id_branch = 0;
    bus.id_alu_operand_a_selector = 0; bus.id_alu_operand_b_selector = 0;
    bus.id_immediate_selector = 0; bus.id_next_pc_selector = 0;
    bus.id_alu_operations_selector = 0;
    bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0; bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0;
    bus.id_pc = 0; bus.id_immediate = 0; bus.flush = 0; bus.freeze = 0;
  endtask

  task automatic drive_load(input logic [4:0] rd);
    idle();
    bus.id_valid = 1; bus.id_load = 1; bus.id_write = 1; bus.id_rd = rd;
    bus.id_pc = 32'h80; bus.id_alu_operand_b_selector = 1;
  endtask

  task automatic drive_consumer(input logic [4:0] rs2);
    idle();
    bus.id_valid = 1; bus.id_uses_rs2 = 1; bus.id_rs2 = rs2; bus.id_store = 1;
    bus.id_branch = 1; bus.id_pc = 32'h100; bus.id_next_pc_selector = 2'b01;
    bus.id_alu_operations_selector = 3'b011;
  endtask

  task automatic rand_id();
    bus.id_valid = ($urandom_range(0, 3) != 0);
    bus.id_write = 1'($urandom); bus.id_store = 1'($urandom);
    bus.id_load = ($urandom_range(0, 1) == 0); bus.id_branch = 1'($urandom);
    bus.id_alu_operand_a_selector = 2'($urandom); bus.id_alu_operand_b_selector = 1'($urandom);
    bus.id_immediate_selector = 2'($urandom); bus.id_next_pc_selector = 2'($urandom);
    bus.id_alu_operations_selector = 3'($urandom);
    bus.id_rs1 = 5'($urandom_range(0, 3)); bus.id_rs2 = 5'($urandom_range(0, 3));
    bus.id_rd = 5'($urandom_range(0, 3));
    bus.id_uses_rs1 = 1'($urandom); bus.id_uses_rs2 = 1'($urandom);
    bus.id_pc = $urandom; bus.id_immediate = $urandom;
  endtask

  task automatic test_reset();
    idle();
    rst = 1; bus.id_valid = 1; bus.id_write = 1;
    tick();
    tick();
    checks++;
    if (dut_ex() !== ex_s'(0)) begin
      errors++; $display("FAIL reset_ex: got %h want 0", dut_ex());
    end
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
    rst = 0;
    idle();
  endtask

  task automatic test_pass_through();
    idle();
    bus.id_valid = 1; bus.id_write = 1; bus.id_alu_operations_selector = 3'b010;
    bus.id_rd = 5; bus.id_pc = 32'h40;
    tick();
    checks++;
    if ({bus.ex_valid, bus.ex_write, bus.ex_alu_operations_selector, bus.ex_rd, bus.ex_pc} !==
        {1'b1, 1'b1, 3'b010, 5'd5, 32'h40}) begin
      errors++;
      $display("FAIL pass_fields: got v%b w%b op%b rd%0d pc%h want v1 w1 op010 rd5 pc40",
               bus.ex_valid, bus.ex_write, bus.ex_alu_operations_selector, bus.ex_rd, bus.ex_pc);
    end
    checks++;
    if (dut_ex() !== m) begin errors++; $display("FAIL pass_model: got %h want %h", dut_ex(), m); end
  endtask

  task automatic test_load_use();
    drive_load(7);
    tick();
    drive_consumer(7);
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b want 1", bus.stall); end
    tick();
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_store !== 1'b0) begin
      errors++; $display("FAIL lu_bubble: got v%b s%b want v0 s0", bus.ex_valid, bus.ex_store);
    end
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL lu_release: got %b want 0", bus.stall); end
    tick();
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_rs2 !== 5'd7 || bus.ex_pc !== 32'h100) begin
      errors++;
      $display("FAIL lu_capture: got v%b rs2 %0d pc %h want v1 rs2 7 pc 100",
               bus.ex_valid, bus.ex_rs2, bus.ex_pc);
    end
    drive_load(0);
    tick();
    drive_consumer(0);
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL lu_rd0_stall: got %b want 0", bus.stall); end
    tick();
    checks++;
    if (bus.ex_valid !== 1'b1) begin errors++; $display("FAIL lu_rd0_cap: got %b want 1", bus.ex_valid); end
  endtask

  task automatic test_flush_vs_hazard();
    drive_load(7);
    tick();
    drive_consumer(7);
    bus.flush = 1;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL fh_stall: got %b want 0", bus.stall); end
    tick();
    checks++;
    if ({bus.ex_valid, bus.ex_store, bus.ex_branch, bus.ex_next_pc_selector} !== 5'b0) begin
      errors++;
      $display("FAIL fh_bubble: got v%b s%b b%b npc%b want all 0", bus.ex_valid, bus.ex_store,
               bus.ex_branch, bus.ex_next_pc_selector);
    end
    idle();
  endtask

  task automatic test_freeze();
    ex_s saved;
    drive_load(7);
    tick();
    saved = dut_ex();
    drive_consumer(7);
    bus.freeze = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.stall !== 1'b1) begin errors++; $display("FAIL frz_stall%0d: got %b want 1", i, bus.stall); end
      tick();
      checks++;
      if (dut_ex() !== saved) begin
        errors++; $display("FAIL frz_hold%0d: got %h want %h", i, dut_ex(), saved);
      end
      bus.id_pc = $urandom; bus.id_immediate = $urandom; bus.id_rd = 5'($urandom);
    end
    bus.freeze = 0;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin errors++; $display("FAIL frz_after: got %b want 1", bus.stall); end
    tick();
    checks++;
    if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL frz_bubble: got %b want 0", bus.ex_valid); end
    idle();
    tick();
  endtask

  task automatic test_rst_mid_stall();
    drive_load(9);
    tick();
    drive_consumer(9);
    bus.freeze = 1;
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (dut_ex() !== ex_s'(0) || bus.stall !== 1'b0) begin
      errors++; $display("FAIL rst_mid: got %h stall %b want 0 stall 0", dut_ex(), bus.stall);
    end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rand_id();
      bus.flush  = ($urandom_range(0, 7) == 0);
      bus.freeze = ($urandom_range(0, 7) == 0);
      rst        = ($urandom_range(0, 63) == 0);
      #1;
      checks++;
      if (bus.stall !== (exp_hazard() && !bus.flush)) begin
        errors++;
        $display("FAIL rnd_stall%0d: got %b want %b", i, bus.stall, exp_hazard() && !bus.flush);
      end
      tick();
      checks++;
      if (dut_ex() !== m) begin errors++; $display("FAIL rnd_ex%0d: got %h want %h", i, dut_ex(), m); end
    end
    rst = 0;
`ifdef HAZARD_STATS_EN
    checks++;
    if (stall_count !== m_stalls || flush_count !== m_flushes) begin
      errors++;
      $display("FAIL rnd_counts: got %0d/%0d want %0d/%0d", stall_count, flush_count,
               m_stalls, m_flushes);
    end
`endif
    idle();
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    idle();
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      drive_load(7);
      tick();
      drive_consumer(7);
      tick();
      tick();
    end
    idle();
    bus.flush = 1;
    tick();
    tick();
    idle();
    checks++;
    if (stall_count !== 32'd3 || flush_count !== 32'd2) begin
      errors++; $display("FAIL stats_counts: got %0d/%0d want 3/2", stall_count, flush_count);
    end
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (stall_count !== 32'd0 || flush_count !== 32'd0) begin
      errors++; $display("FAIL stats_clear: got %0d/%0d want 0/0", stall_count, flush_count);
    end
  endtask
`endif

  initial begin
    m = '0;
    rst = 1;
    idle();
`ifdef HAZARD_STATS_EN
    m_stalls  = 0;
    m_flushes = 0;
`endif
    test_reset();
    test_pass_through();
    test_load_use();
    test_flush_vs_hazard();
    test_freeze();
    test_rst_mid_stall();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
